sha256_digest_reader: RTL
=========================

# sha256_digest_reader

Read-side counterpart of the SHA-256 working/hash register bank. On a `load` pulse the block captures the full 256-bit digest (H0..H7) in one cycle. It then streams the digest out as eight 32-bit words, H0 first, over a valid/ready handshake. It sits between the compression core's final hash registers and the host/output interface, and reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `WORD_W`, default 32: word width in bits.
- `N_WORDS`, default 8: words per digest; the digest width is `WORD_W*N_WORDS`.

Ports:
- `CLK`  in  1: clock.
- `RST`  in  1: reset, asynchronous, active-high.
- `load`  in  1: capture request; honoured only in IDLE.
- `digest_i`  in  256: H0 in [255:224] through H7 in [31:0].
- `abort`  in  1: synchronous cancel of the current stream.
- `out_valid`  out  1: `out_data` holds a valid word.
- `out_ready`  in  1: the consumer accepts the word.
- `out_data`  out  32: current digest word.
- `out_last`  out  1: high with the final word (H7).
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse after H7 is accepted.

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - `load`=1 → latch `digest_i` into the internal buffer, set idx=0, go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - `out_valid`=1 and `out_data`=word[idx], where word[k] = buffer[255-32k -: 32].
  - A transfer occurs when `out_valid` && `out_ready`.
  - On a transfer with idx<7, idx increments.
  - On a transfer with idx=7, go to DONE.
  - `out_last` = (idx==7).
- DONE: `done`=1 for exactly this cycle, then unconditionally go to IDLE.
- `abort`=1 in SEND or DONE → IDLE next cycle.
  - No `done` pulse is produced.
  - A transfer in the same cycle counts on the consumer side, but the stream ends there.
  - `abort` has priority over a transfer and over DONE.
- `load` in SEND or DONE is ignored. The buffer is not overwritten, and `digest_i` changes during SEND have no effect.
- `abort` and `load` together in IDLE: `load` wins and capture proceeds.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` must hold stable.
- `out_valid` never drops before a transfer, except on abort or reset.

## Timing
- Reset values: state=IDLE, idx=0, buffer=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- All outputs are registered or decoded from registered state only; there is no combinational path from `out_ready` to `out_valid`.
- Latency: with `load` sampled at edge 0, `out_valid`=1 with H0 from cycle 1.
- Throughput: one word per cycle with no bubbles while `out_ready`=1.
- Best case with `out_ready` held high:
  - words are transferred in cycles 1..8;
  - `done` is high in cycle 9;
  - state is IDLE and `busy`=0 in cycle 10;
  - the next `load` is accepted in cycle 10.
- `busy` rises in the cycle after `load` is sampled. It stays high through the DONE cycle.
- RST asserted mid-stream clears everything immediately, with no `done` pulse. The first `load` after RST deasserts behaves as a fresh start.
- When `out_valid`=0, `out_data` shows the last presented word (or 0 after reset); consumers must not rely on it.

## Structure
- Shared package `sha256_pkg` holds:
  - constants `WORD_W`=32 and `DIGEST_W`=256;
  - `N_WORDS`=8;
  - a state enum typedef `rd_state_t` {IDLE, SEND, DONE};
  - the SHA-256 initial hash constants H0..H7, reused by the benches.
- The 256-bit buffer is implemented either as a shift-by-32 register or as a static buffer plus a 3-bit idx mux; both are acceptable, but the output timing above is binding.
- The design is a single flat module. A sub-module is not natural at this size, so no word-mux sub-module is split out.

## Test plan
- "abc" digest streamed with `out_ready`=1:
  - stimulus: `load` with `digest_i`=ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  - required: those 8 words in cycles 1..8, `out_last` only on f20015ad, `done` in cycle 9, `busy`=0 in cycle 10.
- Backpressure:
  - stimulus: `out_ready` toggling 1,0,0,1,…;
  - required: `out_data` and `out_last` stable during stalls, no word skipped or repeated, `done` exactly once after the H7 transfer.
- Load while busy:
  - stimulus: a second `load` with 0xFFFF…FF during SEND;
  - required: the stream remains the first digest, and that `load` is ignored.
- Abort:
  - stimulus: `abort` at idx=3;
  - required: `out_valid`=0 the next cycle, no `done`, and a following `load` of the initial H values (6a09e667…5be0cd19) streams from 6a09e667.
- Async reset:
  - stimulus: RST pulsed mid-stream, between clock edges;
  - required: all outputs 0 immediately, and state IDLE after release.
- Back-to-back loads:
  - stimulus: `load` in cycle 10 after a full stream;
  - required: the second digest starts in cycle 11 with no lost words.

Source files
------------

// File: rtl/sha256_pkg.sv
// Constants and types shared by the SHA-256 digest read-side logic and its benches.
package sha256_pkg;

  localparam int WORD_W   = 32;
  localparam int N_WORDS  = 8;
  localparam int DIGEST_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  // Initial hash values H0..H7, H0 in the top word.
  localparam logic [DIGEST_W-1:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

endpackage

// File: rtl/sha256_digest_reader.sv
// Captures a full digest in one cycle and streams it out word by word, H0 first,
// over a valid/ready handshake, with a one-cycle done pulse at the end.
module sha256_digest_reader #(
  parameter int WORD_W  = sha256_pkg::WORD_W,
  parameter int N_WORDS = sha256_pkg::N_WORDS
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      load,
  input  logic [WORD_W*N_WORDS-1:0] digest_i,
  input  logic                      abort,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);
  import sha256_pkg::*;

  localparam int DW    = WORD_W * N_WORDS;
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  rd_state_t        state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [DW-1:0]    buffer_reg, buffer_next;
  logic [WORD_W-1:0] words [N_WORDS];

  // Word k sits in the buffer with H0 at the most significant end.
  generate
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_words
      assign words[gi] = buffer_reg[DW-1-WORD_W*gi -: WORD_W];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      buffer_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      buffer_reg <= buffer_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    buffer_next = buffer_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          buffer_next = digest_i;
          idx_next    = '0;
          state_next  = SEND;
        end
      end
      SEND: begin
        // Abort ends the stream even if the current word is also accepted.
        if (abort) begin
          state_next = IDLE;
        end else if (out_ready) begin
          if (idx_reg == LAST_IDX) state_next = DONE;
          else                     idx_next   = idx_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All outputs decode registered state only; out_ready never reaches them.
  assign out_valid = (state_reg == SEND);
  assign out_data  = words[idx_reg];
  assign out_last  = out_valid && (idx_reg == LAST_IDX);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

endmodule
